// File: rtl/zx_vram_pkg.sv
// Shared definitions for the screen-RAM arbiter: default widths and the CPU-side FSM encoding.
package zx_vram_pkg;
  localparam int AW_DEF  = 13;
  localparam int DW_DEF  = 8;
  localparam int STALL_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ACK  = 2'd1,
    FWD_ACK = 2'd2,
    WR_ACK  = 2'd3
  } state_t;
endpackage

// File: rtl/vram_wbuf.sv
// One-entry posted-write buffer; a load in the same cycle as a drain keeps the entry valid.
module vram_wbuf #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          drain,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic [AW-1:0] cmp_addr,
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          hit
);
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else if (load) begin
      wb_valid <= 1'b1;
      wb_addr  <= load_addr;
      wb_data  <= load_data;
    end else if (drain) begin
      wb_valid <= 1'b0;
    end
  end

  assign hit = wb_valid && (cmp_addr == wb_addr);
endmodule

// File: rtl/vram_arbiter.sv
// Single-port screen RAM arbiter: video reads always win, CPU reads take free slots or
// forward from the write buffer, posted CPU writes drain into whatever slot is left.
module vram_arbiter
  import zx_vram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vid_req,
  input  logic [AW-1:0]      vid_addr,
  output logic               vid_valid,
  output logic [DW-1:0]      vid_data,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [DW-1:0]      cpu_wdata,
  output logic               cpu_ack,
  output logic [DW-1:0]      cpu_rdata,
  output logic [AW-1:0]      ram_addr,
  output logic               ram_we,
  output logic [DW-1:0]      ram_wdata,
  input  logic [DW-1:0]      ram_rdata,
  output logic [STALL_W-1:0] stall_cnt
);
  state_t        state, state_next;
  logic          wb_valid, wb_hit;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] rd_q;
  logic          cpu_rd, cpu_wr, rd_miss, rd_grant, drain, wr_accept, stall;

  // CPU handshake: cpu_req is only looked at in IDLE; each ACK state is a single-cycle pulse.
  assign cpu_rd    = (state == IDLE) && cpu_req && !cpu_we;
  assign cpu_wr    = (state == IDLE) && cpu_req && cpu_we;
  assign rd_miss   = cpu_rd && !wb_hit;
  assign rd_grant  = rd_miss && !vid_req;
  assign drain     = wb_valid && !vid_req && !rd_miss;
  assign wr_accept = cpu_wr && (!wb_valid || drain);
  assign stall     = (rd_miss && vid_req) || (cpu_wr && !wr_accept);

  vram_wbuf #(.AW(AW), .DW(DW)) u_wbuf (
    .clk       (clk),
    .reset     (reset),
    .load      (wr_accept),
    .drain     (drain),
    .load_addr (cpu_addr),
    .load_data (cpu_wdata),
    .cmp_addr  (cpu_addr),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .hit       (wb_hit)
  );

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE: begin
        if (cpu_rd && wb_hit) state_next = FWD_ACK;
        else if (rd_grant)    state_next = RD_ACK;
        else if (wr_accept)   state_next = WR_ACK;
        else                  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Slot priority: video, then CPU read miss, then buffer drain.
  always_comb begin
    ram_addr  = wb_addr;
    ram_we    = 1'b0;
    ram_wdata = wb_data;
    if (vid_req)      ram_addr = vid_addr;
    else if (rd_miss) ram_addr = cpu_addr;
    else if (drain)   ram_we   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      vid_valid <= 1'b0;
      rd_q      <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_next;
      vid_valid <= vid_req;
      if (cpu_rd && wb_hit) rd_q <= wb_data;
      if (stall && (stall_cnt != {STALL_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign vid_data  = ram_rdata;
  assign cpu_ack   = (state != IDLE);
  assign cpu_rdata = (state == RD_ACK) ? ram_rdata : rd_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a cycle table for the main scenarios plus hand-written
// sequences for stall-counter saturation and reset in the middle of a write.
module tb_vram_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk, reset;
  logic          vid_req, vid_valid;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [15:0]   stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  vram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .stall_cnt(stall_cnt)
  );

  // Clock / reset and RAM macro model (1-cycle synchronous read, preloaded on reset)
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
      mem[13'h1800] <= 8'h47;
      mem[13'h0000] <= 8'h5C;
      ram_rdata <= '0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    logic          vreq;
    logic [AW-1:0] vaddr;
    logic          creq, cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwd;
    logic          e_vv, chk_vd;
    logic [DW-1:0] e_vd;
    logic          e_ack, chk_rd;
    logic [DW-1:0] e_rd;
    logic          e_we, chk_addr;
    logic [AW-1:0] e_addr;
    logic [15:0]   e_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    input logic vreq, input logic [AW-1:0] vaddr,
    input logic creq, input logic cwe, input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
    input logic e_vv, input logic chk_vd, input logic [DW-1:0] e_vd,
    input logic e_ack, input logic chk_rd, input logic [DW-1:0] e_rd,
    input logic e_we, input logic chk_addr, input logic [AW-1:0] e_addr,
    input logic [15:0] e_stall);
    vec_t r;
    r.vreq = vreq; r.vaddr = vaddr; r.creq = creq; r.cwe = cwe; r.caddr = caddr; r.cwd = cwd;
    r.e_vv = e_vv; r.chk_vd = chk_vd; r.e_vd = e_vd;
    r.e_ack = e_ack; r.chk_rd = chk_rd; r.e_rd = e_rd;
    r.e_we = e_we; r.chk_addr = chk_addr; r.e_addr = e_addr; r.e_stall = e_stall;
    return r;
  endfunction

  // Driver and checker tasks; inputs change on the falling edge, outputs sampled 1 ns later.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vreq, input logic [AW-1:0] vaddr, input logic creq,
                       input logic cwe, input logic [AW-1:0] caddr, input logic [DW-1:0] cwd);
    @(negedge clk);
    vid_req = vreq; vid_addr = vaddr;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    #1;
  endtask

  int we_seen;
  int ack_seen;

  initial begin
    reset = 1'b1;
    vid_req = 0; vid_addr = '0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ack", cpu_ack, 0);
    check("rst_vv", vid_valid, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_we", ram_we, 0);
    reset = 1'b0;

    // Video only; read collision; posted write with forward; back-to-back writes.
    vecs.push_back(v(1,13'h1800, 0,0,0,0,       0,0,0,     0,0,0,     0,1,13'h1800, 0));
    vecs.push_back(v(0,0,        0,0,0,0,       1,1,8'h47, 0,0,0,     0,0,0,        0));
    vecs.push_back(v(1,13'h1800, 1,0,13'h0000,0, 0,0,0,    0,0,0,     0,1,13'h1800, 0));
    vecs.push_back(v(0,0,        1,0,13'h0000,0, 1,1,8'h47, 0,0,0,    0,1,13'h0000, 1));
    vecs.push_back(v(0,0,        1,0,13'h0000,0, 0,0,0,    1,1,8'h5C, 0,0,0,        1));
    vecs.push_back(v(0,0,        0,0,0,0,       0,0,0,     0,0,0,     0,0,0,        1));
    vecs.push_back(v(1,13'h0010, 1,1,13'h0123,8'hAA, 0,0,0, 0,0,0,   0,1,13'h0010, 1));
    vecs.push_back(v(1,13'h0010, 1,1,13'h0123,8'hAA, 1,0,0, 1,0,0,   0,1,13'h0010, 1));
    vecs.push_back(v(1,13'h0010, 0,0,0,0,       1,0,0,     0,0,0,     0,1,13'h0010, 1));
    vecs.push_back(v(1,13'h0010, 1,0,13'h0123,0, 1,0,0,    0,0,0,     0,1,13'h0010, 1));
    vecs.push_back(v(1,13'h0010, 1,0,13'h0123,0, 1,0,0,    1,1,8'hAA, 0,1,13'h0010, 1));
    vecs.push_back(v(0,0,        0,0,0,0,       1,0,0,     0,0,0,     1,1,13'h0123, 1));
    vecs.push_back(v(0,0,        1,0,13'h0123,0, 0,0,0,    0,0,0,     0,1,13'h0123, 1));
    vecs.push_back(v(0,0,        1,0,13'h0123,0, 0,0,0,    1,1,8'hAA, 0,0,0,        1));
    vecs.push_back(v(0,0,        0,0,0,0,       0,0,0,     0,0,0,     0,0,0,        1));
    vecs.push_back(v(1,13'h0020, 1,1,13'h0001,8'h11, 0,0,0, 0,0,0,   0,1,13'h0020, 1));
    vecs.push_back(v(1,13'h0020, 1,1,13'h0001,8'h11, 1,0,0, 1,0,0,   0,1,13'h0020, 1));
    vecs.push_back(v(1,13'h0020, 1,1,13'h0002,8'h22, 1,0,0, 0,0,0,   0,1,13'h0020, 1));
    vecs.push_back(v(0,0,        1,1,13'h0002,8'h22, 1,0,0, 0,0,0,   1,1,13'h0001, 2));
    vecs.push_back(v(0,0,        1,1,13'h0002,8'h22, 0,0,0, 1,0,0,   1,1,13'h0002, 2));
    vecs.push_back(v(0,0,        0,0,0,0,       0,0,0,     0,0,0,     0,0,0,        2));
    vecs.push_back(v(0,0,        1,0,13'h0001,0, 0,0,0,    0,0,0,     0,1,13'h0001, 2));
    vecs.push_back(v(0,0,        1,0,13'h0001,0, 0,0,0,    1,1,8'h11, 0,0,0,        2));
    vecs.push_back(v(0,0,        0,0,0,0,       0,0,0,     0,0,0,     0,0,0,        2));
    vecs.push_back(v(0,0,        1,0,13'h0002,0, 0,0,0,    0,0,0,     0,1,13'h0002, 2));
    vecs.push_back(v(0,0,        1,0,13'h0002,0, 0,0,0,    1,1,8'h22, 0,0,0,        2));
    vecs.push_back(v(0,0,        0,0,0,0,       0,0,0,     0,0,0,     0,0,0,        2));

    foreach (vecs[i]) begin
      drive(vecs[i].vreq, vecs[i].vaddr, vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd);
      check($sformatf("v%0d_vid_valid", i), vid_valid, vecs[i].e_vv);
      check($sformatf("v%0d_cpu_ack", i), cpu_ack, vecs[i].e_ack);
      check($sformatf("v%0d_ram_we", i), ram_we, vecs[i].e_we);
      check($sformatf("v%0d_stall_cnt", i), stall_cnt, vecs[i].e_stall);
      if (vecs[i].chk_vd)   check($sformatf("v%0d_vid_data", i), vid_data, vecs[i].e_vd);
      if (vecs[i].chk_rd)   check($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_rd);
      if (vecs[i].chk_addr) check($sformatf("v%0d_ram_addr", i), ram_addr, vecs[i].e_addr);
      if (vecs[i].e_we)     check($sformatf("v%0d_ram_wdata", i), ram_wdata,
                                  (vecs[i].e_addr == 13'h0123) ? 8'hAA :
                                  (vecs[i].e_addr == 13'h0001) ? 8'h11 : 8'h22);
    end

    // Stall counter saturation: buffer full, video every cycle, second write held.
    drive(1, 13'h0030, 1, 1, 13'h0100, 8'h33);
    check("sat_accept_we", ram_we, 0);
    drive(1, 13'h0030, 1, 1, 13'h0100, 8'h33);
    check("sat_first_ack", cpu_ack, 1);
    we_seen = 0;
    ack_seen = 0;
    for (int c = 0; c < 70000; c++) begin
      drive(1, 13'h0030, 1, 1, 13'h0101, 8'h44);
      if (ram_we) we_seen++;
      if (cpu_ack) ack_seen++;
    end
    check("sat_no_we", we_seen, 0);
    check("sat_no_ack", ack_seen, 0);
    check("sat_stall_max", stall_cnt, 16'hFFFF);
    drive(0, 0, 1, 1, 13'h0101, 8'h44);
    check("sat_no_wrap", stall_cnt, 16'hFFFF);
    check("sat_drain_we", ram_we, 1);
    check("sat_drain_addr", ram_addr, 13'h0100);
    check("sat_drain_data", ram_wdata, 8'h33);
    drive(0, 0, 1, 1, 13'h0101, 8'h44);
    check("sat_second_ack", cpu_ack, 1);
    check("sat_second_drain_addr", ram_addr, 13'h0101);
    check("sat_second_drain_data", ram_wdata, 8'h44);
    drive(0, 0, 0, 0, 0, 0);
    check("sat_hold", stall_cnt, 16'hFFFF);

    // Reset mid-write: accept under video, reset during the ack cycle.
    drive(1, 13'h0040, 1, 1, 13'h0200, 8'h55);
    check("rmw_accept_we", ram_we, 0);
    drive(1, 13'h0040, 1, 1, 13'h0200, 8'h55);
    reset = 1'b1;
    check("rmw_ack_pre", cpu_ack, 1);
    check("rmw_we_pre", ram_we, 0);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    check("rmw_ack_dropped", cpu_ack, 0);
    check("rmw_stall_zero", stall_cnt, 0);
    check("rmw_vv_zero", vid_valid, 0);
    check("rmw_rdata_zero", cpu_rdata, 0);
    we_seen = 0;
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 0, 0, 0, 0);
      if (ram_we) we_seen++;
    end
    check("rmw_no_drain", we_seen, 0);
    drive(0, 0, 1, 0, 13'h0200, 0);
    check("rmw_read_addr", ram_addr, 13'h0200);
    drive(0, 0, 1, 0, 13'h0200, 0);
    check("rmw_read_ack", cpu_ack, 1);
    check("rmw_read_data", cpu_rdata, 8'h00);
    drive(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
